// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// 16 lines x 32 bytes; address split tag=[31:9], index=[8:5], word=[4:2].
// The FSM walks IDLE -> (WRITEBACK) -> ALLOCATE -> IDLE on a miss, while the
// CPU pipeline is frozen through cpu_stall_o.
// Optional build macro DCACHE_STATS_EN adds hit_count_o / miss_count_o.
module dcache_ctrl (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [31:0]  cpu_addr_i,
   input  logic [31:0]  cpu_data_i,
   input  logic         cpu_MemRead_i,
   input  logic         cpu_MemWrite_i,
   output logic [31:0]  cpu_data_o,
   output logic         cpu_stall_o,
   output logic [31:0]  mem_addr_o,
   output logic [255:0] mem_data_o,
   output logic         mem_enable_o,
   output logic         mem_write_o,
`ifdef DCACHE_STATS_EN
   output logic [31:0]  hit_count_o,
   output logic [31:0]  miss_count_o,
`endif
   input  logic [255:0] mem_data_i,
   input  logic         mem_ack_i
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WRITEBACK = 2'd1;
   localparam logic [1:0] ALLOCATE  = 2'd2;

   logic [1:0]   state;
   logic [1:0]   next_state;

   logic [15:0]  valid;
   logic [15:0]  dirty;
   logic [22:0]  tag_mem  [0:15];
   logic [255:0] data_mem [0:15];

   logic [22:0]  tag;
   logic [3:0]   index;
   logic [2:0]   word;
   logic         req;
   logic         hit;
   logic         write_hit;
   logic         fill;
   logic         unused_addr_bits;

   assign tag   = cpu_addr_i[31:9];
   assign index = cpu_addr_i[8:5];
   assign word  = cpu_addr_i[4:2];
   assign req   = cpu_MemRead_i | cpu_MemWrite_i;
   assign hit   = valid[index] & (tag_mem[index] == tag);

   // A write strobe wins over a simultaneous read strobe; only IDLE may commit.
   assign write_hit = (state == IDLE) & cpu_MemWrite_i & hit;
   // A fill happens only when the memory answers the refill request.
   assign fill      = (state == ALLOCATE) & mem_ack_i;

   // Byte-offset bits are irrelevant for word accesses.
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   // Stall and load data are combinational so a hit adds no latency.
   always_comb begin
      cpu_stall_o = req & ~hit & ~rst_i;
      if (cpu_MemRead_i & ~cpu_MemWrite_i & hit & ~rst_i) begin
         cpu_data_o = data_mem[index][{word, 5'd0} +: 32];
      end else begin
         cpu_data_o = 32'd0;
      end
   end

   // State register: reset abandons any outstanding memory transaction.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: ack is only meaningful in the state waiting for it.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req & ~hit) begin
               if (valid[index] & dirty[index]) begin
                  next_state = WRITEBACK;
               end else begin
                  next_state = ALLOCATE;
               end
            end else begin
               next_state = IDLE;
            end
         end
         WRITEBACK: begin
            if (mem_ack_i) begin
               next_state = ALLOCATE;
            end else begin
               next_state = WRITEBACK;
            end
         end
         ALLOCATE: begin
            if (mem_ack_i) begin
               next_state = IDLE;
            end else begin
               next_state = ALLOCATE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic: memory request signals driven purely from the state.
   always_comb begin
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = 32'd0;
      mem_data_o   = 256'd0;
      case (state)
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {tag_mem[index], index, 5'd0};
            mem_data_o   = data_mem[index];
         end
         ALLOCATE: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b0;
            mem_addr_o   = {tag, index, 5'd0};
            mem_data_o   = 256'd0;
         end
         default: begin
            mem_enable_o = 1'b0;
            mem_write_o  = 1'b0;
            mem_addr_o   = 32'd0;
            mem_data_o   = 256'd0;
         end
      endcase
   end

   // Line status bits: cleared by reset, set by fill or write hit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid <= 16'd0;
         dirty <= 16'd0;
      end else if (fill) begin
         valid[index] <= 1'b1;
         dirty[index] <= 1'b0;
      end else if (write_hit) begin
         dirty[index] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid bits guard their contents.
   always_ff @(posedge clk_i) begin
      if (fill) begin
         tag_mem[index]  <= tag;
         data_mem[index] <= mem_data_i;
      end else if (write_hit) begin
         data_mem[index][{word, 5'd0} +: 32] <= cpu_data_i;
      end
   end

`ifdef DCACHE_STATS_EN
   logic alloc_done;

   // Event counters; the hit that replays a just-filled miss is not counted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_count_o  <= 32'd0;
         miss_count_o <= 32'd0;
         alloc_done   <= 1'b0;
      end else begin
         alloc_done <= fill;
         if ((state == IDLE) & req & ~hit) begin
            miss_count_o <= miss_count_o + 32'd1;
         end
         if ((state == IDLE) & req & hit & ~alloc_done) begin
            hit_count_o <= hit_count_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl. Inputs change 1 ns after the
// rising edge; outputs are checked 1 ns after inputs settle.
module tb_dcache_ctrl;

   logic         clk_i;
   logic         rst_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic         cpu_MemRead_i;
   logic         cpu_MemWrite_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_count_o;
   logic [31:0]  miss_count_o;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [255:0] line_a;
   logic [255:0] line_b;

   dcache_ctrl dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .cpu_addr_i     (cpu_addr_i),
      .cpu_data_i     (cpu_data_i),
      .cpu_MemRead_i  (cpu_MemRead_i),
      .cpu_MemWrite_i (cpu_MemWrite_i),
      .cpu_data_o     (cpu_data_o),
      .cpu_stall_o    (cpu_stall_o),
      .mem_addr_o     (mem_addr_o),
      .mem_data_o     (mem_data_o),
      .mem_enable_o   (mem_enable_o),
      .mem_write_o    (mem_write_o),
`ifdef DCACHE_STATS_EN
      .hit_count_o    (hit_count_o),
      .miss_count_o   (miss_count_o),
`endif
      .mem_data_i     (mem_data_i),
      .mem_ack_i      (mem_ack_i)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] w1);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
      l[63:32] = w1;
      return l;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; cpu_MemRead_i = 1'b1; cpu_MemWrite_i = 1'b0;
      cpu_addr_i = 32'h40; cpu_data_i = 32'd0; mem_ack_i = 1'b0; mem_data_i = 256'd0;
      #2;
      n_tests++; if (cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", cpu_stall_o); end
      n_tests++; if (mem_enable_o !== 1'b0 || mem_write_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ctl: got en=%b wr=%b want 0 0", mem_enable_o, mem_write_o); end
      n_tests++; if (mem_addr_o !== 32'd0 || mem_data_o !== 256'd0 || cpu_data_o !== 32'd0) begin n_fail++; $display("FAIL rst_data: got addr=%h cpu_data=%h want 0", mem_addr_o, cpu_data_o); end
`ifdef DCACHE_STATS_EN
      n_tests++; if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin n_fail++; $display("FAIL rst_counters: got %0d %0d want 0 0", hit_count_o, miss_count_o); end
`endif
      tick();
      cpu_MemRead_i = 1'b0;
      tick();
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_read_miss();
      cpu_MemRead_i = 1'b1; cpu_addr_i = 32'h40;
      #1;
      n_tests++; if (cpu_stall_o !== 1'b1 || mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL miss_idle: got stall=%b en=%b want 1 0", cpu_stall_o, mem_enable_o); end
      tick();
      n_tests++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h40) begin n_fail++; $display("FAIL alloc_req: got en=%b wr=%b addr=%h want 1 0 40", mem_enable_o, mem_write_o, mem_addr_o); end
      tick(); tick();
      n_tests++; if (cpu_stall_o !== 1'b1 || mem_enable_o !== 1'b1) begin n_fail++; $display("FAIL alloc_hold: got stall=%b en=%b want 1 1", cpu_stall_o, mem_enable_o); end
      mem_data_i = line_a; mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0; mem_data_i = 256'd0; cpu_addr_i = 32'h44;
      #1;
      n_tests++; if (cpu_data_o !== 32'hDEADBEEF || cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL fill_hit: got data=%h stall=%b want deadbeef 0", cpu_data_o, cpu_stall_o); end
      n_tests++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL fill_idle_en: got %b want 0", mem_enable_o); end
      tick();
   endtask

   task automatic test_write_hit();
      cpu_MemRead_i = 1'b0; cpu_MemWrite_i = 1'b1; cpu_addr_i = 32'h44; cpu_data_i = 32'h12345678;
      #1;
      n_tests++; if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'd0) begin n_fail++; $display("FAIL write_hit: got stall=%b data=%h want 0 0", cpu_stall_o, cpu_data_o); end
      tick();
      cpu_MemWrite_i = 1'b0; cpu_MemRead_i = 1'b1;
      #1;
      n_tests++; if (cpu_data_o !== 32'h12345678 || cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL read_after_write: got data=%h stall=%b want 12345678 0", cpu_data_o, cpu_stall_o); end
      cpu_addr_i = 32'h40;
      #1;
      n_tests++; if (cpu_data_o !== 32'hA0000000) begin n_fail++; $display("FAIL read_word0: got %h want a0000000", cpu_data_o); end
      cpu_addr_i = 32'h44;
      tick();
   endtask

   task automatic test_writeback();
      cpu_addr_i = 32'h240;
      #1;
      n_tests++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL conflict_stall: got %b want 1", cpu_stall_o); end
      tick();
      n_tests++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h40) begin n_fail++; $display("FAIL wb_req: got en=%b wr=%b addr=%h want 1 1 40", mem_enable_o, mem_write_o, mem_addr_o); end
      n_tests++; if (mem_data_o[63:32] !== 32'h12345678 || mem_data_o[31:0] !== 32'hA0000000) begin n_fail++; $display("FAIL wb_data: got w1=%h w0=%h want 12345678 a0000000", mem_data_o[63:32], mem_data_o[31:0]); end
      tick();
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      n_tests++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h240) begin n_fail++; $display("FAIL wb_to_alloc: got en=%b wr=%b addr=%h want 1 0 240", mem_enable_o, mem_write_o, mem_addr_o); end
      cpu_MemRead_i = 1'b0;
      tick();
      n_tests++; if (mem_enable_o !== 1'b1 || cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL alloc_no_req: got en=%b stall=%b want 1 0", mem_enable_o, cpu_stall_o); end
      mem_data_i = line_b; mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0; mem_data_i = 256'd0; cpu_MemRead_i = 1'b1;
      #1;
      n_tests++; if (cpu_data_o !== 32'hB0000000 || cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL fill_after_drop: got data=%h stall=%b want b0000000 0", cpu_data_o, cpu_stall_o); end
      cpu_MemRead_i = 1'b0;
      tick();
`ifdef DCACHE_STATS_EN
      n_tests++; if (hit_count_o !== 32'd2 || miss_count_o !== 32'd2) begin n_fail++; $display("FAIL stats: got hit=%0d miss=%0d want 2 2", hit_count_o, miss_count_o); end
`endif
   endtask

   task automatic test_both_strobes_glitch();
      cpu_MemRead_i = 1'b1; cpu_MemWrite_i = 1'b1; cpu_addr_i = 32'h248; cpu_data_i = 32'hCAFEF00D;
      mem_ack_i = 1'b1;
      #1;
      n_tests++; if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'd0) begin n_fail++; $display("FAIL both_strobes: got stall=%b data=%h want 0 0", cpu_stall_o, cpu_data_o); end
      tick();
      mem_ack_i = 1'b0; cpu_MemWrite_i = 1'b0;
      #1;
      n_tests++; if (cpu_data_o !== 32'hCAFEF00D || mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL both_write_done: got data=%h en=%b want cafef00d 0", cpu_data_o, mem_enable_o); end
      cpu_addr_i = 32'h40;
      #1;
      n_tests++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL evict_stall: got %b want 1", cpu_stall_o); end
      tick();
      n_tests++; if (mem_write_o !== 1'b1 || mem_addr_o !== 32'h240 || mem_data_o[95:64] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL dirty_wb: got wr=%b addr=%h w2=%h want 1 240 cafef00d", mem_write_o, mem_addr_o, mem_data_o[95:64]); end
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      n_tests++; if (mem_write_o !== 1'b0 || mem_addr_o !== 32'h40 || mem_enable_o !== 1'b1) begin n_fail++; $display("FAIL alloc_after_wb: got wr=%b addr=%h en=%b want 0 40 1", mem_write_o, mem_addr_o, mem_enable_o); end
   endtask

   task automatic test_reset_in_alloc();
      rst_i = 1'b1;
      #1;
      n_tests++; if (mem_enable_o !== 1'b0 || cpu_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_in_alloc: got en=%b stall=%b want 0 0", mem_enable_o, cpu_stall_o); end
      cpu_MemRead_i = 1'b0;
      tick();
      rst_i = 1'b0;
      tick();
      mem_data_i = line_a; mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      tick();
      n_tests++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL late_ack: got en=%b want 0", mem_enable_o); end
      cpu_MemRead_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cpu_addr_i = 32'(i) << 5;
         #1;
         n_tests++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL line_invalid_%0d: got stall=%b want 1", i, cpu_stall_o); end
      end
      cpu_addr_i = 32'h240;
      #1;
      n_tests++; if (cpu_stall_o !== 1'b1 || cpu_data_o !== 32'd0) begin n_fail++; $display("FAIL old_tag_invalid: got stall=%b data=%h want 1 0", cpu_stall_o, cpu_data_o); end
      cpu_MemRead_i = 1'b0;
`ifdef DCACHE_STATS_EN
      n_tests++; if (hit_count_o !== 32'd0 || miss_count_o !== 32'd0) begin n_fail++; $display("FAIL stats_cleared: got %0d %0d want 0 0", hit_count_o, miss_count_o); end
`endif
      tick();
   endtask

   initial begin
      line_a = mk_line(32'hA0000000, 32'hDEADBEEF);
      line_b = mk_line(32'hB0000000, 32'hB0000001);
      test_reset();
      test_read_miss();
      test_write_hit();
      test_writeback();
      test_both_strobes_glitch();
      test_reset_in_alloc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have the port cpu_addr_i, input, 32 bits: MEM-stage byte address (EXMEM ALU result); tag=[31:9], index=[8:5], word=[4:2].
REQ-004 The block SHALL have the port cpu_data_i, input, 32 bits: store data from EXMEM.
REQ-005 The block SHALL have the ports cpu_MemRead_i and cpu_MemWrite_i, input, 1 bit each: MEM-stage access strobes.
REQ-006 The block SHALL have the port cpu_data_o, output, 32 bits: load data to MEMWB.
REQ-007 The block SHALL have the port cpu_stall_o, output, 1 bit: freezes PC, IFID, IDEX, EXMEM and MEMWB while high.
REQ-008 The block SHALL have the port mem_addr_o, output, 32 bits: block-aligned memory address (bits [4:0]=0).
REQ-009 The block SHALL have the port mem_data_o, output, 256 bits: victim line for write-back.
REQ-010 The block SHALL have the ports mem_enable_o and mem_write_o, output, 1 bit each: memory request and direction.
REQ-011 The block SHALL have the port mem_data_i, input, 256 bits: refill line from memory.
REQ-012 The block SHALL have the port mem_ack_i, input, 1 bit: one-cycle completion pulse from memory.

Function
REQ-013 The cache SHALL be direct-mapped, 16 lines x 32 bytes, write-back, write-allocate; each line SHALL hold valid, dirty, 23-bit tag and 256-bit data.
REQ-014 req is defined as cpu_MemRead_i|cpu_MemWrite_i; when both strobes are high, the access SHALL be treated as a write.
REQ-015 hit is defined as valid[index] & (tag[index]==cpu_addr_i[31:9]); the hit SHALL be evaluated combinationally.
REQ-016 cpu_stall_o SHALL equal req & ~hit, combinationally; with no req, stall SHALL be 0 in every state.
REQ-017 On a read hit, cpu_data_o SHALL present word [4:2] of the line in the same cycle, with zero added latency; otherwise cpu_data_o SHALL be 0.
REQ-018 On a write hit in IDLE, the addressed word SHALL be written at the clock edge and dirty SHALL be set to 1.
REQ-019 The FSM states SHALL be IDLE, WRITEBACK and ALLOCATE.
REQ-020 From IDLE, a req with a miss and a dirty victim SHALL go to WRITEBACK; a miss with a clean or invalid victim SHALL go to ALLOCATE.
REQ-021 In WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line; the FSM SHALL hold until mem_ack_i, then go to ALLOCATE.
REQ-022 In ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}; on mem_ack_i the line SHALL be filled from mem_data_i with valid=1, dirty=0 and the new tag, and the FSM SHALL go to IDLE.
REQ-023 The access SHALL then complete as a hit in the next IDLE cycle, giving a miss penalty of memory latency + 1 cycle.
REQ-024 In IDLE, mem_enable_o SHALL be 0 and mem_ack_i SHALL be ignored; mem_ack_i arriving with any state other than the one awaiting it SHALL have no effect.
REQ-025 If req drops during WRITEBACK or ALLOCATE, the transaction SHALL still complete and the line fill SHALL occur.
REQ-026 The CPU SHALL hold the address and data stable while stalled; the block SHALL not latch the request.

Reset
REQ-027 On rst_i high, asynchronously, the FSM SHALL go to IDLE and all valid and dirty bits SHALL clear.
REQ-028 On rst_i high, mem_enable_o, mem_write_o and cpu_stall_o SHALL go to 0; mem_addr_o, mem_data_o and cpu_data_o SHALL go to 0.
REQ-029 Tag and data arrays need not be reset.
REQ-030 A reset during WRITEBACK or ALLOCATE SHALL abandon the transaction; a later mem_ack_i SHALL be ignored.

Configuration
REQ-031 When DCACHE_STATS_EN is defined, the block SHALL add 32-bit outputs hit_count_o and miss_count_o, both reset to 0.
REQ-032 miss_count_o SHALL increment on each IDLE->WRITEBACK or IDLE->ALLOCATE transition.
REQ-033 hit_count_o SHALL increment on each IDLE req&hit cycle not immediately following an ALLOCATE completion.
REQ-034 Both counters SHALL wrap at 2^32.
REQ-035 When DCACHE_STATS_EN is undefined, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-036 After reset, a read of 0x0000_0040 SHALL give stall=1 and ALLOCATE with mem_addr_o=0x40; after ack (data word1=0xDEADBEEF), a read of 0x44 in the next cycle SHALL give cpu_data_o=0xDEADBEEF with stall=0.
REQ-037 A write of 0x1234_5678 to 0x44 (a hit) SHALL raise no stall and set dirty; a following read of 0x44 SHALL return 0x12345678.
REQ-038 A read of 0x0000_0240 (same index, new tag) SHALL cause WRITEBACK with mem_addr_o=0x40 and mem_data_o word1=0x12345678, then ALLOCATE with mem_addr_o=0x240.
REQ-039 Asserting rst_i in ALLOCATE, then a late mem_ack_i, SHALL leave the FSM in IDLE with all lines invalid and mem_enable_o=0.
REQ-040 Asserting both MemRead and MemWrite on a hit SHALL perform a write; a mem_ack_i glitch in IDLE SHALL be ignored.
REQ-041 With DCACHE_STATS_EN defined, REQ-036 to REQ-038 SHALL end with hit_count_o=2 and miss_count_o=2.
